cw_program_sequencer: RTL and testbench

Upstream control-word source for the LEGv8 datapath board test. Replaces direct DIP-switch drive of `ControlWord` and manual button clocking with a small program buffer. Control words are captured from the switches into a DEPTH-entry buffer and replayed one per datapath clock pulse, either single-stepped from a button or free-running. With an empty buffer it passes the switches straight through.

---
 rtl/board_test_pkg.sv | 8 +
 rtl/cw_program_sequencer_if.sv | 29 ++
 rtl/cw_program_sequencer_button_debounce.sv | 50 +++++
 rtl/cw_program_sequencer.sv | 124 ++++++++++++
 tb/tb_cw_program_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/board_test_pkg.sv
// Shared types and defaults for the LEGv8 board-test control-word sequencer.
package board_test_pkg;
  localparam int CW_WIDTH         = 34;
  localparam int DEBOUNCE_DEFAULT = 500000;
  localparam int RUN_DIV_DEFAULT  = 25000000;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} seq_state_t;
endpackage

// File: rtl/cw_program_sequencer_if.sv
// Board-side signal bundle of the sequencer: switches/buttons in, datapath drive and status out.
interface cw_program_sequencer_if #(
  parameter int CW_WIDTH = 34,
  parameter int DEPTH    = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [CW_WIDTH-1:0] sw_cw;
  logic                btn_load_n;
  logic                btn_step_n;
  logic                btn_run_n;
  logic                clear;
  logic [CW_WIDTH-1:0] control_word;
  logic                dp_clock;
  logic                run_mode;
  logic [AW:0]         count;
  logic [AW-1:0]       rd_ptr;
  logic                full;

  modport master (
    output sw_cw, btn_load_n, btn_step_n, btn_run_n, clear,
    input  control_word, dp_clock, run_mode, count, rd_ptr, full
  );

  modport slave (
    input  sw_cw, btn_load_n, btn_step_n, btn_run_n, clear,
    output control_word, dp_clock, run_mode, count, rd_ptr, full
  );
endinterface

// File: rtl/cw_program_sequencer_button_debounce.sv
// Button debouncer: 2-FF synchroniser, level accepted after DEBOUNCE_CYCLES stable samples,
// 1-cycle press pulse on the released-to-pressed transition.
module button_debounce
  import board_test_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             w_pressed;

  assign w_pressed = ~r_sync[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], btn_n};
      r_press <= 1'b0;
      // Any sample matching the accepted level restarts the stability window.
      if (w_pressed != r_level) begin
        if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_level <= w_pressed;
          r_press <= w_pressed;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;
endmodule

// File: rtl/cw_program_sequencer.sv
// Control-word program buffer replayed onto the datapath one dp_clock pulse per step,
// single-stepped or free-running; passes the switches through when the buffer is empty.
module cw_program_sequencer
  import board_test_pkg::*;
#(
  parameter int CW_WIDTH        = board_test_pkg::CW_WIDTH,
  parameter int DEPTH           = 16,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int RUN_DIV         = RUN_DIV_DEFAULT,
  parameter int STROBE_CYCLES   = 4
) (
  input logic                   clock,
  input logic                   reset,
  cw_program_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(RUN_DIV);
  localparam int SW = $clog2(STROBE_CYCLES) + 1;

  logic [CW_WIDTH-1:0] r_mem [DEPTH];
  seq_state_t          r_state;
  logic [CW_WIDTH-1:0] r_cw;
  logic                r_dp_clk;
  logic                r_run;
  logic [AW:0]         r_count;
  logic [AW-1:0]       r_rd_ptr;
  logic [DW-1:0]       r_div;
  logic [SW-1:0]       r_strobe;

  logic w_load_press, w_step_press, w_run_press;
  logic w_load_lvl, w_step_lvl, w_run_lvl, w_unused_levels;
  logic w_full, w_empty, w_idle, w_div_tick, w_step_req, w_take_step, w_load;
  logic [CW_WIDTH-1:0] w_sel;
  logic [AW:0]         w_ptr_inc;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clock(clock), .reset(reset), .btn_n(bus.btn_load_n), .level(w_load_lvl), .press(w_load_press));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clock(clock), .reset(reset), .btn_n(bus.btn_step_n), .level(w_step_lvl), .press(w_step_press));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clock(clock), .reset(reset), .btn_n(bus.btn_run_n), .level(w_run_lvl), .press(w_run_press));

  assign w_unused_levels = w_load_lvl & w_step_lvl & w_run_lvl;

  assign w_full      = (r_count == (AW+1)'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_idle      = (r_state == IDLE);
  assign w_div_tick  = (r_div == DW'(RUN_DIV - 1));
  assign w_step_req  = r_run ? w_div_tick : w_step_press;
  assign w_take_step = w_idle && w_step_req;
  // A step in the same cycle as a load wins; the load press is simply lost.
  assign w_load      = w_load_press && w_idle && !r_run && !w_full && !w_take_step && !bus.clear;
  assign w_sel       = w_empty ? bus.sw_cw : r_mem[r_rd_ptr];
  assign w_ptr_inc   = {1'b0, r_rd_ptr} + (AW+1)'(1);

  always_ff @(posedge clock) begin
    if (w_load) r_mem[r_count[AW-1:0]] <= bus.sw_cw;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cw     <= '0;
      r_dp_clk <= 1'b0;
      r_run    <= 1'b0;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_div    <= '0;
      r_strobe <= '0;
    end else if (bus.clear) begin
      // control_word deliberately kept so the datapath sees no spurious word change.
      r_state  <= IDLE;
      r_dp_clk <= 1'b0;
      r_run    <= 1'b0;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_div    <= '0;
      r_strobe <= '0;
    end else begin
      if (w_run_press && !w_empty) begin
        r_run <= ~r_run;
        r_div <= '0;
      end else if (r_run) begin
        r_div <= w_div_tick ? '0 : r_div + DW'(1);
      end

      if (w_load) r_count <= r_count + (AW+1)'(1);

      case (r_state)
        IDLE: begin
          if (w_step_req) begin
            r_cw    <= w_sel;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_dp_clk <= 1'b1;
          r_strobe <= '0;
          r_state  <= PULSE;
        end
        PULSE: begin
          if (r_strobe == SW'(STROBE_CYCLES - 1)) begin
            r_dp_clk <= 1'b0;
            r_state  <= HOLD;
          end else begin
            r_strobe <= r_strobe + SW'(1);
          end
        end
        HOLD: begin
          if (!w_empty) r_rd_ptr <= (w_ptr_inc == r_count) ? '0 : w_ptr_inc[AW-1:0];
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.control_word = r_cw;
  assign bus.dp_clock     = r_dp_clk;
  assign bus.run_mode     = r_run;
  assign bus.count        = r_count;
  assign bus.rd_ptr       = r_rd_ptr;
  assign bus.full         = w_full;
endmodule

// File: tb/tb_cw_program_sequencer.sv
// Self-checking bench for cw_program_sequencer against a queue-based program model.
module tb_cw_program_sequencer;
  localparam int CWW     = 34;
  localparam int DEPTH   = 4;
  localparam int STROBE  = 2;
  localparam int RUN_DIV = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  cw_program_sequencer_if #(.CW_WIDTH(CWW), .DEPTH(DEPTH)) bus();

  cw_program_sequencer #(
    .CW_WIDTH(CWW), .DEPTH(DEPTH), .DEBOUNCE_CYCLES(4),
    .RUN_DIV(RUN_DIV), .STROBE_CYCLES(STROBE)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Program model: loaded words in order plus index of next word to execute.
  logic [CWW-1:0] prog[$];
  int             rd_idx = 0;

  int             rise_t[$];
  logic [CWW-1:0] rise_cw[$];
  logic [CWW-1:0] pre_cw[$];
  int             hi_len[$];

  function automatic logic [CWW-1:0] rand_cw();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[CWW-1:0];
  endfunction

  function automatic logic [CWW-1:0] model_step();
    logic [CWW-1:0] w;
    if (prog.size() == 0) begin
      w = bus.sw_cw;
    end else begin
      w = prog[rd_idx];
      rd_idx = (rd_idx + 1) % prog.size();
    end
    return w;
  endfunction

  // Drives buttons low inside [lo,hi] windows for ncyc cycles and records dp_clock pulses.
  task automatic run_cycles(input int ncyc, input int ld_lo, input int ld_hi,
                            input int st_lo, input int st_hi, input int rn_lo, input int rn_hi);
    logic           prev_dp;
    logic [CWW-1:0] prev_cw;
    int             hl;
    rise_t.delete(); rise_cw.delete(); pre_cw.delete(); hi_len.delete();
    prev_dp = bus.dp_clock;
    prev_cw = bus.control_word;
    hl = 0;
    for (int i = 0; i < ncyc; i++) begin
      bus.btn_load_n = !(i >= ld_lo && i <= ld_hi);
      bus.btn_step_n = !(i >= st_lo && i <= st_hi);
      bus.btn_run_n  = !(i >= rn_lo && i <= rn_hi);
      @(negedge clock);
      if (bus.dp_clock && !prev_dp) begin
        rise_t.push_back(i);
        rise_cw.push_back(bus.control_word);
        pre_cw.push_back(prev_cw);
      end
      if (bus.dp_clock) hl++;
      if (!bus.dp_clock && prev_dp) begin
        hi_len.push_back(hl);
        hl = 0;
      end
      prev_dp = bus.dp_clock;
      prev_cw = bus.control_word;
    end
    bus.btn_load_n = 1'b1;
    bus.btn_step_n = 1'b1;
    bus.btn_run_n  = 1'b1;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
    prog.delete();
    rd_idx = 0;
  endtask

  task automatic load_word(input logic [CWW-1:0] w);
    bus.sw_cw = w;
    run_cycles(25, 0, $urandom_range(6, 12), -1, -2, -1, -2);
    if (prog.size() < DEPTH) prog.push_back(w);
  endtask

  task automatic step_and_check(input string name);
    logic [CWW-1:0] exp;
    exp = model_step();
    run_cycles(40, -1, -2, 0, 9, -1, -2);
    n_checks++;
    if (rise_t.size() !== 1) begin
      n_fail++; $display("FAIL %s_pulses: got %0d pulses expected 1", name, rise_t.size());
    end
    if (rise_t.size() >= 1) begin
      n_checks++;
      if (rise_cw[0] !== exp) begin
        n_fail++; $display("FAIL %s_word: got %0h expected %0h", name, rise_cw[0], exp);
      end
      n_checks++;
      if (pre_cw[0] !== exp) begin
        n_fail++; $display("FAIL %s_setup: got %0h expected %0h", name, pre_cw[0], exp);
      end
    end
    if (hi_len.size() >= 1) begin
      n_checks++;
      if (hi_len[0] !== STROBE) begin
        n_fail++; $display("FAIL %s_width: got %0d expected %0d", name, hi_len[0], STROBE);
      end
    end
    n_checks++;
    if (bus.control_word !== exp) begin
      n_fail++; $display("FAIL %s_hold: got %0h expected %0h", name, bus.control_word, exp);
    end
  endtask

  task automatic test_reset();
    bit found;
    bus.sw_cw = '0; bus.clear = 1'b0;
    bus.btn_load_n = 1'b1; bus.btn_step_n = 1'b1; bus.btn_run_n = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({bus.control_word, bus.dp_clock, bus.run_mode, bus.count, bus.rd_ptr, bus.full} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: cw=%0h dp=%0b run=%0b count=%0d rd=%0d full=%0b expected all 0",
               bus.control_word, bus.dp_clock, bus.run_mode, bus.count, bus.rd_ptr, bus.full);
    end
    // Async reset in the middle of a pass-through pulse.
    bus.sw_cw = rand_cw();
    bus.btn_step_n = 1'b0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clock);
      if (bus.dp_clock) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL reset_pulse_seen: got no pulse expected one within 30 cycles");
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (bus.dp_clock !== 1'b0) begin
      n_fail++; $display("FAIL reset_async_dp: got %0b expected 0", bus.dp_clock);
    end
    bus.btn_step_n = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if (bus.control_word !== '0) begin
      n_fail++; $display("FAIL reset_cw: got %0h expected 0", bus.control_word);
    end
    prog.delete();
    rd_idx = 0;
  endtask

  task automatic test_debounce();
    bus.sw_cw = rand_cw();
    run_cycles(20, 0, 2, -1, -2, -1, -2);
    n_checks++;
    if (bus.count !== 3'd0) begin
      n_fail++; $display("FAIL debounce_glitch: got count %0d expected 0", bus.count);
    end
    run_cycles(25, 0, 9, -1, -2, -1, -2);
    prog.push_back(bus.sw_cw);
    n_checks++;
    if (bus.count !== 3'd1) begin
      n_fail++; $display("FAIL debounce_press: got count %0d expected 1", bus.count);
    end
  endtask

  task automatic test_load_full();
    do_clear();
    @(negedge clock);
    n_checks++;
    if (bus.count !== 3'd0) begin
      n_fail++; $display("FAIL clear_count: got %0d expected 0", bus.count);
    end
    for (int v = 1; v <= 5; v++) begin
      load_word(CWW'(v));
      n_checks++;
      if (bus.count !== 3'(prog.size()) || bus.full !== (prog.size() == DEPTH)) begin
        n_fail++;
        $display("FAIL load_%0d: got count %0d full %0b expected count %0d full %0b",
                 v, bus.count, bus.full, prog.size(), prog.size() == DEPTH);
      end
    end
  endtask

  task automatic test_step_wrap();
    for (int k = 0; k < 5; k++) step_and_check($sformatf("step%0d", k));
    n_checks++;
    if (bus.rd_ptr !== 2'(rd_idx) || rd_idx != 1) begin
      n_fail++; $display("FAIL step_rd_ptr: got %0d expected %0d (model 1)", bus.rd_ptr, rd_idx);
    end
  endtask

  task automatic test_run();
    logic [CWW-1:0] exp;
    // Run on, with a step press mid-run that must not add a pulse.
    run_cycles(120, -1, -2, 40, 49, 0, 9);
    n_checks++;
    if (bus.run_mode !== 1'b1) begin
      n_fail++; $display("FAIL run_on: got %0b expected 1", bus.run_mode);
    end
    n_checks++;
    if (rise_t.size() < 5) begin
      n_fail++; $display("FAIL run_pulses: got %0d pulses expected at least 5", rise_t.size());
    end
    for (int j = 0; j < rise_t.size(); j++) begin
      exp = model_step();
      n_checks++;
      if (rise_cw[j] !== exp || pre_cw[j] !== exp) begin
        n_fail++; $display("FAIL run_word%0d: got %0h/%0h expected %0h", j, pre_cw[j], rise_cw[j], exp);
      end
      if (j > 0) begin
        n_checks++;
        if (rise_t[j] - rise_t[j-1] != RUN_DIV) begin
          n_fail++; $display("FAIL run_period%0d: got %0d expected %0d", j, rise_t[j] - rise_t[j-1], RUN_DIV);
        end
      end
      if (j < hi_len.size()) begin
        n_checks++;
        if (hi_len[j] != STROBE) begin
          n_fail++; $display("FAIL run_width%0d: got %0d expected %0d", j, hi_len[j], STROBE);
        end
      end
    end
    run_cycles(40, -1, -2, -1, -2, 0, 9);
    for (int j = 0; j < rise_t.size(); j++) begin
      exp = model_step();
      n_checks++;
      if (rise_cw[j] !== exp) begin
        n_fail++; $display("FAIL run_stop_word%0d: got %0h expected %0h", j, rise_cw[j], exp);
      end
    end
    n_checks++;
    if (bus.run_mode !== 1'b0) begin
      n_fail++; $display("FAIL run_off: got %0b expected 0", bus.run_mode);
    end
    run_cycles(50, -1, -2, -1, -2, -1, -2);
    n_checks++;
    if (rise_t.size() != 0) begin
      n_fail++; $display("FAIL run_stopped: got %0d pulses expected 0", rise_t.size());
    end
    n_checks++;
    if (bus.rd_ptr !== 2'(rd_idx)) begin
      n_fail++; $display("FAIL run_rd_ptr: got %0d expected %0d", bus.rd_ptr, rd_idx);
    end
  endtask

  task automatic test_passthrough_clear();
    logic [CWW-1:0] exp;
    logic [CWW-1:0] cw_hold;
    bit found;
    do_clear();
    @(negedge clock);
    n_checks++;
    if (bus.count !== 3'd0 || bus.rd_ptr !== 2'd0 || bus.full !== 1'b0) begin
      n_fail++; $display("FAIL pt_clear: got count %0d rd %0d full %0b expected 0 0 0", bus.count, bus.rd_ptr, bus.full);
    end
    bus.sw_cw = 34'h2_DEADBEEF;
    step_and_check("passthrough");
    // Load and step pressed together: the step wins, nothing is loaded.
    bus.sw_cw = rand_cw();
    exp = bus.sw_cw;
    run_cycles(40, 0, 9, 0, 9, -1, -2);
    n_checks++;
    if (rise_t.size() != 1 || bus.count !== 3'd0 || bus.control_word !== exp) begin
      n_fail++;
      $display("FAIL load_vs_step: got pulses %0d count %0d cw %0h expected 1 0 %0h",
               rise_t.size(), bus.count, bus.control_word, exp);
    end
    load_word(rand_cw());
    load_word(rand_cw());
    run_cycles(10, -1, -2, -1, -2, 0, 9);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (bus.dp_clock) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL clear_pulse_seen: got no run pulse expected one within 40 cycles");
    end
    cw_hold = bus.control_word;
    n_checks++;
    if (cw_hold !== prog[0]) begin
      n_fail++; $display("FAIL clear_run_word: got %0h expected %0h", cw_hold, prog[0]);
    end
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
    n_checks++;
    if (bus.dp_clock !== 1'b0 || bus.count !== 3'd0 || bus.run_mode !== 1'b0 ||
        bus.rd_ptr !== 2'd0 || bus.control_word !== cw_hold) begin
      n_fail++;
      $display("FAIL clear_in_pulse: got dp %0b count %0d run %0b rd %0d cw %0h expected 0 0 0 0 %0h",
               bus.dp_clock, bus.count, bus.run_mode, bus.rd_ptr, bus.control_word, cw_hold);
    end
    prog.delete();
    rd_idx = 0;
    run_cycles(40, -1, -2, -1, -2, -1, -2);
    n_checks++;
    if (rise_t.size() != 0) begin
      n_fail++; $display("FAIL clear_stops_run: got %0d pulses expected 0", rise_t.size());
    end
  endtask

  task automatic test_random_program();
    int n;
    int k;
    do_clear();
    n = $urandom_range(1, DEPTH);
    for (int i = 0; i < n; i++) load_word(rand_cw());
    n_checks++;
    if (bus.count !== 3'(n) || bus.full !== (n == DEPTH)) begin
      n_fail++; $display("FAIL rand_load: got count %0d full %0b expected %0d %0b", bus.count, bus.full, n, n == DEPTH);
    end
    k = $urandom_range(3, 8);
    for (int i = 0; i < k; i++) begin
      bus.sw_cw = rand_cw();
      step_and_check($sformatf("rand_step%0d", i));
    end
    n_checks++;
    if (bus.rd_ptr !== 2'(rd_idx)) begin
      n_fail++; $display("FAIL rand_rd_ptr: got %0d expected %0d", bus.rd_ptr, rd_idx);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_load_full();
    test_step_wrap();
    test_run();
    test_passthrough_clear();
    test_random_program();
    test_random_program();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
